xy_noc_bus: RTL and testbench



---
 rtl/noc_pkg.sv | 42 ++++
 rtl/noc_tag_match.sv | 61 ++++++
 rtl/xy_noc_bus.sv | 141 ++++++++++++++
 tb/tb_xy_noc_bus.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the XY multicast bus and the data encoder that feeds it:
// packet struct, tag-width helpers, the INACTIVE tag pattern and FSM states.
package noc_pkg;

  localparam int NOC_DATA_WIDTH = 16;
  localparam int NOC_NUM_ROW    = 4;
  localparam int NOC_NUM_COL    = 4;

  // Row tag width: enough bits to name every row plus one extension bit.
  function automatic int rid_width(input int num_row);
    return $clog2(num_row) + 1;
  endfunction

  // Column tag width: enough bits to name every column plus one extension bit.
  function automatic int cid_width(input int num_col);
    return $clog2(num_col) + 1;
  endfunction

  // Width of the shared config id bus (wider of the two tag widths).
  function automatic int tag_max_width(input int rid_w, input int cid_w);
    return (rid_w > cid_w) ? rid_w : cid_w;
  endfunction

  localparam int NOC_RID_W = rid_width(NOC_NUM_ROW);
  localparam int NOC_CID_W = cid_width(NOC_NUM_COL);

  // All-ones pattern; any tag whose MSB is set is INACTIVE and never matches.
  localparam int                    TAG_W_MAX    = 8;
  localparam logic [TAG_W_MAX-1:0]  TAG_INACTIVE = 8'hFF;

  typedef struct packed {
    logic [NOC_RID_W-1:0]        row_id;
    logic [NOC_CID_W-1:0]        col_id;
    logic [2*NOC_DATA_WIDTH-1:0] data;
  } noc_pkt_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_DELIVER = 1'b1
  } noc_state_t;

endpackage

// File: rtl/noc_tag_match.sv
// Tag register file (one row tag per PE row, one column tag per PE) with its
// config write port, and the combinational match mask for the incoming packet.
module noc_tag_match
  import noc_pkg::*;
#(
  parameter int NUM_ROW = 4,
  parameter int NUM_COL = 4,
  parameter int RID_W   = $clog2(NUM_ROW) + 1,
  parameter int CID_W   = $clog2(NUM_COL) + 1,
  parameter int ID_W    = (RID_W > CID_W) ? RID_W : CID_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic                       cfg_is_row,
  input  logic [$clog2(NUM_ROW)-1:0] cfg_row,
  input  logic [$clog2(NUM_COL)-1:0] cfg_col,
  input  logic [ID_W-1:0]            cfg_id,
  input  logic [RID_W-1:0]           in_row_id,
  input  logic [CID_W-1:0]           in_col_id,
  output logic [NUM_ROW*NUM_COL-1:0] match
);

  localparam logic [RID_W-1:0] ROW_OFF = TAG_INACTIVE[RID_W-1:0];
  localparam logic [CID_W-1:0] COL_OFF = TAG_INACTIVE[CID_W-1:0];

  logic [RID_W-1:0] row_tag [NUM_ROW];
  logic [CID_W-1:0] col_tag [NUM_ROW][NUM_COL];

  // Tag storage: reset to INACTIVE, written one entry per cfg_we strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        row_tag[r] <= ROW_OFF;
        for (int c = 0; c < NUM_COL; c++) begin
          col_tag[r][c] <= COL_OFF;
        end
      end
    end else if (cfg_we) begin
      if (cfg_is_row) begin
        row_tag[cfg_row] <= cfg_id[RID_W-1:0];
      end else begin
        col_tag[cfg_row][cfg_col] <= cfg_id[CID_W-1:0];
      end
    end
  end

  // Match mask from current tags; INACTIVE tags (MSB set) never match.
  always_comb begin
    match = '0;
    for (int r = 0; r < NUM_ROW; r++) begin
      for (int c = 0; c < NUM_COL; c++) begin
        match[r*NUM_COL+c] = (row_tag[r] == in_row_id) &&
                             (col_tag[r][c] == in_col_id) &&
                             !row_tag[r][RID_W-1] &&
                             !col_tag[r][c][CID_W-1];
      end
    end
  end

endmodule

// File: rtl/xy_noc_bus.sv
// Multicast XY bus top: holds one packet, strobes it to every matched PE and
// retires it once all of them have accepted. Counts packets that match nobody.
module xy_noc_bus
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int NUM_COL    = 4,
  parameter int RID_W      = $clog2(NUM_ROW) + 1,
  parameter int CID_W      = $clog2(NUM_COL) + 1,
  localparam int ID_W      = (RID_W > CID_W) ? RID_W : CID_W,
  localparam int NUM_PE    = NUM_ROW * NUM_COL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic                       cfg_is_row,
  input  logic [$clog2(NUM_ROW)-1:0] cfg_row,
  input  logic [$clog2(NUM_COL)-1:0] cfg_col,
  input  logic [ID_W-1:0]            cfg_id,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RID_W-1:0]           in_row_id,
  input  logic [CID_W-1:0]           in_col_id,
  input  logic [2*DATA_WIDTH-1:0]    in_data,
  output logic [NUM_PE-1:0]          pe_valid,
  input  logic [NUM_PE-1:0]          pe_ready,
  output logic [2*DATA_WIDTH-1:0]    pe_data,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  noc_state_t              state;
  noc_state_t              state_next;
  logic [NUM_PE-1:0]       match;
  logic [NUM_PE-1:0]       mask;
  logic [NUM_PE-1:0]       done;
  logic [NUM_PE-1:0]       pe_hs;
  logic [2*DATA_WIDTH-1:0] data_hold;
  logic                    retire;
  logic                    capture;

  noc_tag_match #(
    .NUM_ROW (NUM_ROW),
    .NUM_COL (NUM_COL),
    .RID_W   (RID_W),
    .CID_W   (CID_W),
    .ID_W    (ID_W)
  ) u_tag_match (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_is_row (cfg_is_row),
    .cfg_row    (cfg_row),
    .cfg_col    (cfg_col),
    .cfg_id     (cfg_id),
    .in_row_id  (in_row_id),
    .in_col_id  (in_col_id),
    .match      (match)
  );

  assign pe_hs   = pe_valid & pe_ready;
  assign capture = in_valid & in_ready;
  assign pe_data = data_hold;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a capture always leads to DELIVER; a retire without a new
  // packet falls back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (capture) begin
          state_next = ST_DELIVER;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        if (retire && !capture) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DELIVER;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: per-PE strobes for undelivered matches; ready when empty or retiring.
  always_comb begin
    pe_valid = '0;
    retire   = 1'b0;
    busy     = 1'b0;
    in_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !rst;
      end
      ST_DELIVER: begin
        busy     = 1'b1;
        pe_valid = mask & ~done;
        retire   = ((done | (pe_valid & pe_ready)) == mask);
        in_ready = retire && !rst;
      end
      default: begin
        pe_valid = '0;
      end
    endcase
  end

  // Hold register, delivered-set tracking and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask      <= '0;
      done      <= '0;
      data_hold <= '0;
      drop_cnt  <= 16'd0;
    end else begin
      if (capture) begin
        mask      <= match;
        done      <= '0;
        data_hold <= in_data;
      end else if (state == ST_DELIVER) begin
        done <= done | pe_hs;
      end
      if ((state == ST_DELIVER) && retire && (mask == '0) && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_xy_noc_bus.sv
// Directed bench for xy_noc_bus with a scoreboard of expected deliveries.
module tb_xy_noc_bus;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int NP = NR * NC;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic        cfg_is_row;
  logic [1:0]  cfg_row;
  logic [1:0]  cfg_col;
  logic [2:0]  cfg_id;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_row_id;
  logic [2:0]  in_col_id;
  logic [31:0] in_data;
  logic [15:0] pe_valid;
  logic [15:0] pe_ready;
  logic [31:0] pe_data;
  logic        busy;
  logic [15:0] drop_cnt;

  typedef struct packed {
    logic [15:0] mask;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_drop;
  logic [15:0] held_mask;
  logic [2:0]  rt [NR];
  logic [2:0]  ct [NR][NC];

  xy_noc_bus dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_is_row (cfg_is_row),
    .cfg_row    (cfg_row),
    .cfg_col    (cfg_col),
    .cfg_id     (cfg_id),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row_id  (in_row_id),
    .in_col_id  (in_col_id),
    .in_data    (in_data),
    .pe_valid   (pe_valid),
    .pe_ready   (pe_ready),
    .pe_data    (pe_data),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      rt[r] = 3'b111;
      for (int c = 0; c < NC; c++) ct[r][c] = 3'b111;
    end
  endtask

  function automatic logic [15:0] model_mask(input logic [2:0] rid, input logic [2:0] cid);
    logic [15:0] m;
    m = 16'h0000;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (rt[r] == rid && ct[r][c] == cid && !rt[r][2] && !ct[r][c][2])
          m[r*NC+c] = 1'b1;
    return m;
  endfunction

  task automatic cfg_row_w(input logic [1:0] r, input logic [2:0] id);
    cfg_we = 1'b1; cfg_is_row = 1'b1; cfg_row = r; cfg_col = 2'd0; cfg_id = id;
    tick();
    cfg_we = 1'b0;
    rt[r] = id;
  endtask

  task automatic cfg_col_w(input logic [1:0] r, input logic [1:0] c, input logic [2:0] id);
    cfg_we = 1'b1; cfg_is_row = 1'b0; cfg_row = r; cfg_col = c; cfg_id = id;
    tick();
    cfg_we = 1'b0;
    ct[r][c] = id;
  endtask

  task automatic send(input logic [2:0] rid, input logic [2:0] cid, input logic [31:0] d);
    in_valid = 1'b1; in_row_id = rid; in_col_id = cid; in_data = d;
  endtask

  // Called right after the capturing edge: record what the PEs should see.
  task automatic push_exp();
    exp_t e;
    e.mask = model_mask(in_row_id, in_col_id);
    e.data = in_data;
    if (e.mask == 16'h0000) exp_drop = exp_drop + 16'd1;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {16'h0000, pe_valid}, {16'h0000, e.mask});
      chk({tag, "_data"}, pe_data, e.data);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_is_row = 1'b0; cfg_row = 2'd0; cfg_col = 2'd0;
    cfg_id = 3'd0; in_valid = 1'b0; in_row_id = 3'd0; in_col_id = 3'd0;
    in_data = 32'h0; pe_ready = 16'h0000; exp_drop = 16'h0000; held_mask = 16'h0000;
    model_reset();

    // Reset state
    tick(); tick();
    settle();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_pe_valid", {16'h0, pe_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", {16'h0, drop_cnt}, 32'd0);
    chk("rst_pe_data", pe_data, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single delivery to PE(0,2)
    cfg_row_w(2'd0, 3'd0);
    for (int c = 0; c < NC; c++) cfg_col_w(2'd0, c[1:0], c[2:0]);
    pe_ready = 16'hFFFF;
    send(3'd0, 3'd2, 32'hA5A5_0001);
    settle();
    chk("basic_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    push_exp();
    in_valid = 1'b0;
    settle();
    pop_chk("basic");
    chk("basic_busy", {31'd0, busy}, 32'd1);
    tick();
    settle();
    chk("basic_busy_fall", {31'd0, busy}, 32'd0);
    chk("basic_pe_idle", {16'h0, pe_valid}, 32'd0);

    // Multicast to column 0 of every row, row 0 ready first
    for (int r = 0; r < NR; r++) cfg_row_w(r[1:0], 3'd1);
    for (int r = 0; r < NR; r++) cfg_col_w(r[1:0], 2'd0, 3'd0);
    pe_ready = 16'h000F;
    send(3'd1, 3'd0, 32'h1234_5678);
    tick();
    held_mask = model_mask(3'd1, 3'd0);
    push_exp();
    in_valid = 1'b0;
    settle();
    pop_chk("mc_c1");
    chk("mc_c1_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    settle();
    chk("mc_c2_valid", {16'h0, pe_valid}, {16'h0, held_mask & ~16'h0001});
    chk("mc_c2_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    pe_ready = 16'hFFFF;
    settle();
    chk("mc_c3_valid", {16'h0, pe_valid}, {16'h0, held_mask & ~16'h0001});
    chk("mc_c3_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    settle();
    chk("mc_done_busy", {31'd0, busy}, 32'd0);

    // Reset while a packet is stalled in DELIVER
    pe_ready = 16'h0000;
    send(3'd1, 3'd0, 32'h5555_AAAA);
    tick();
    push_exp();
    in_valid = 1'b0;
    settle();
    pop_chk("rst_mid_pre");
    rst = 1'b1;
    tick();
    settle();
    model_reset();
    chk("rst_mid_pe_valid", {16'h0, pe_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_drop", {16'h0, drop_cnt}, {16'h0, exp_drop});
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;

    // No match: all tags INACTIVE after reset
    pe_ready = 16'hFFFF;
    send(3'd3, 3'd3, 32'hDEAD_BEEF);
    settle();
    chk("nm_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    push_exp();
    in_valid = 1'b0;
    settle();
    pop_chk("nm");
    chk("nm_busy", {31'd0, busy}, 32'd1);
    tick();
    settle();
    chk("nm_busy_fall", {31'd0, busy}, 32'd0);
    chk("nm_drop", {16'h0, drop_cnt}, {16'h0, exp_drop});

    // Back-to-back stream to PE(1,1)
    cfg_row_w(2'd1, 3'd2);
    cfg_col_w(2'd1, 2'd1, 3'd1);
    pe_ready = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      send(3'd2, 3'd1, 32'hB000_0000 + k);
      settle();
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      if (k > 0) pop_chk("b2b");
      tick();
      push_exp();
    end
    in_valid = 1'b0;
    settle();
    pop_chk("b2b_last");
    tick();
    settle();
    chk("b2b_busy_fall", {31'd0, busy}, 32'd0);

    // Retag PE(0,2) while a packet to it is stalled
    cfg_row_w(2'd0, 3'd0);
    cfg_col_w(2'd0, 2'd2, 3'd2);
    pe_ready = 16'h0000;
    send(3'd0, 3'd2, 32'hC0C0_0000);
    tick();
    held_mask = model_mask(3'd0, 3'd2);
    push_exp();
    in_valid = 1'b0;
    settle();
    pop_chk("cfg_held");
    cfg_col_w(2'd0, 2'd2, 3'd3);
    settle();
    chk("cfg_held_valid", {16'h0, pe_valid}, {16'h0, held_mask});
    chk("cfg_held_data", pe_data, 32'hC0C0_0000);
    pe_ready = 16'hFFFF;
    send(3'd0, 3'd3, 32'hC0C0_0001);
    settle();
    chk("cfg_retire_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    push_exp();
    send(3'd0, 3'd2, 32'hC0C0_0002);
    settle();
    pop_chk("cfg_new_tag");
    chk("cfg_new_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    push_exp();
    in_valid = 1'b0;
    settle();
    pop_chk("cfg_old_tag");
    tick();
    settle();
    chk("cfg_drop", {16'h0, drop_cnt}, {16'h0, exp_drop});
    chk("cfg_busy_fall", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
